// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl - main control FSM of the multi-cycle MIPS CPU.
//
// Walks every instruction through fetch, decode, execute, memory and
// write-back. All datapath selects and strobes are Moore outputs decoded
// from the state register. The exceptions are FETCH (PC/IR loads wait for
// mem_ready) and DECODE (illegal_op flags an unknown opcode).
//
// Optional feature: define MC_ANDI_EN to decode andi (001100) through
// ANDI_EX/ANDI_WB. Without it, andi is an illegal opcode.
//
// Ports:
//   clk, rst         rising-edge clock, async active-high reset
//   opcode[5:0]      IR[31:26], sampled only in DECODE and MEM_ADR
//   mem_ready        memory finishes the current access this cycle
//   pc_write, pc_write_cond, pc_source[1:0]   PC update controls
//   i_or_d, mem_read, mem_write, ir_write     memory interface controls
//   mem_to_reg, reg_dst, reg_write            register file controls
//   alu_src_a, alu_src_b[1:0], alu_op[1:0]    ALU operand/op selects
//   illegal_op       one-cycle pulse in DECODE for an unknown opcode
//   state_o          current state (debug)
module mc_main_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef MC_ANDI_EN
  localparam logic [5:0] OP_ANDI = 6'b001100;
`endif

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEM_ADR = 4'd2,  MEM_RD  = 4'd3,
    MEM_WB  = 4'd4,  MEM_WR  = 4'd5,  R_EX    = 4'd6,  R_WB    = 4'd7,
    BEQ     = 4'd8,  JUMP    = 4'd9,  ADDI_EX = 4'd10, ADDI_WB = 4'd11,
    ANDI_EX = 4'd12, ANDI_WB = 4'd13
  } state_t;

  state_t state, state_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_n;
  end

  // Next state. Encodings that are not decoded below (14-15, and 12-13
  // without andi) fall to the default and recover to FETCH.
  always_comb begin
    state_n = FETCH;
    case (state)
      FETCH:   state_n = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_n = MEM_ADR;
          OP_R:         state_n = R_EX;
          OP_BEQ:       state_n = BEQ;
          OP_J:         state_n = JUMP;
          OP_ADDI:      state_n = ADDI_EX;
`ifdef MC_ANDI_EN
          OP_ANDI:      state_n = ANDI_EX;
`endif
          default:      state_n = FETCH;
        endcase
      end
      MEM_ADR: state_n = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:  state_n = mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:  state_n = mem_ready ? FETCH : MEM_WR;
      R_EX:    state_n = R_WB;
      ADDI_EX: state_n = ADDI_WB;
`ifdef MC_ANDI_EN
      ANDI_EX: state_n = ANDI_WB;
`endif
      default: state_n = FETCH;
    endcase
  end

  // Outputs. Everything is forced low while rst is high, so FETCH's
  // mem_read does not leak out during reset.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    state_o       = '0;
    if (!rst) begin
      state_o = state;
      case (state)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          alu_src_b  = 2'b11;
          // Illegal exactly when decode falls back to FETCH.
          illegal_op = (state_n == FETCH);
        end
        MEM_ADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        R_EX: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        BEQ: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        ADDI_WB: reg_write = 1'b1;
`ifdef MC_ANDI_EN
        ANDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 2'b11;
        end
        ANDI_WB: reg_write = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule
